// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// wait-counter width and the big-endian byte-lane mapping.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    localparam int DMEM_WAIT_W = 4;

    // Big-endian: the byte at offset 0 of a word lives in the top lane.
    localparam int DMEM_LANES    = 4;
    localparam int DMEM_MSB_LANE = DMEM_LANES - 1;

    function automatic logic [7:0] dmem_lane_byte(input logic [31:0] word, input int offset);
        return word[8*(DMEM_MSB_LANE - offset) +: 8];
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Byte-organised storage with a 4-byte synchronous write and a registered
// 32-bit big-endian read port. Storage contents survive reset.
module dmem_byte_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 128
) (
    input  logic                             clk,
    input  logic                             rst_n_i,
    input  logic                             we_i,
    input  logic                             re_i,
    input  logic                             zero_i,
    input  logic [$clog2(DEPTH_BYTES)-3:0]   widx_i,
    input  logic [31:0]                      wdata_i,
    output logic [31:0]                      rdata_o
);

    localparam int AW = $clog2(DEPTH_BYTES);

    logic [7:0]  mem_q [DEPTH_BYTES];
    logic [31:0] rdata_q;
    logic [31:0] rd_word;

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < DMEM_LANES; k++) begin
            rd_word[8*(DMEM_MSB_LANE - k) +: 8] = mem_q[{widx_i, 2'(k)}];
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int k = 0; k < DMEM_LANES; k++) begin
                mem_q[{widx_i, 2'(k)}] <= dmem_lane_byte(wdata_i, k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= zero_i ? '0 : rd_word;
        end
    end

    assign rdata_o = rdata_q;

    logic unused_aw;
    assign unused_aw = (AW > 2);

endmodule

// File: rtl/data_mem_responder.sv
// Slow data-memory responder: captures a CPU word access, waits WAIT_CYCLES,
// then commits/reads and pulses ready. Optional misaligned-access error via
// the DMEM_MISALIGN_ERR_EN macro.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 128,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        RD,
    input  logic        WR,
    input  logic [31:0] DAddr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam logic [DMEM_WAIT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : DMEM_WAIT_W'(WAIT_CYCLES - 1);

    dmem_state_e            state_q, state_d;
    logic [DMEM_WAIT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [31:0]            data_q, data_d;
    logic                   wr_q, wr_d;
    logic                   enter_resp;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_d       = wr_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (RD || WR) begin
                    addr_d = DAddr[AW-1:0];
                    data_d = DataIn;
                    wr_d   = WR;
                    cnt_d  = CNT_LOAD;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        wr_q   <= wr_d;
    end

    // With zero wait states the memory acts on the same edge that captures,
    // so the live request is used instead of the not-yet-loaded registers.
    logic [AW-1:0] acc_addr;
    logic [31:0]   acc_data;
    logic          acc_wr;
    logic          misalign;

    assign acc_addr = (state_q == ST_IDLE) ? DAddr[AW-1:0] : addr_q;
    assign acc_data = (state_q == ST_IDLE) ? DataIn : data_q;
    assign acc_wr   = (state_q == ST_IDLE) ? WR : wr_q;

`ifdef DMEM_MISALIGN_ERR_EN
    assign misalign = (acc_addr[1:0] != 2'b00);
    assign err      = (state_q == ST_RESP) && (addr_q[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
    assign err      = 1'b0;
`endif

    dmem_byte_ram #(
        .DEPTH_BYTES(DEPTH_BYTES)
    ) u_ram (
        .clk     (clk),
        .rst_n_i (Reset),
        .we_i    (enter_resp && acc_wr && !misalign && Reset),
        .re_i    (enter_resp && !acc_wr && Reset),
        .zero_i  (misalign),
        .widx_i  (acc_addr[AW-1:2]),
        .wdata_i (acc_data),
        .rdata_o (DataOut)
    );

    assign ready = (state_q == ST_RESP);
    assign busy  = (state_q != ST_IDLE);

    logic unused_bits;
    assign unused_bits = ^{DAddr[31:AW], addr_q[1:0]};

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responders (1, 0 and 3 wait states) exercised with
// hand-computed vectors. Honours DMEM_MISALIGN_ERR_EN like the RTL.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic [2:0]  rst_n = 3'b000;
    logic [2:0]  rd = '0, wr = '0;
    logic [31:0] addr [3];
    logic [31:0] din  [3];
    logic [31:0] dout [3];
    logic [2:0]  rdy, bsy, erra;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        data_mem_responder #(
            .DEPTH_BYTES(128),
            .WAIT_CYCLES(W)
        ) u_dut (
            .clk     (clk),
            .Reset   (rst_n[g]),
            .RD      (rd[g]),
            .WR      (wr[g]),
            .DAddr   (addr[g]),
            .DataIn  (din[g]),
            .DataOut (dout[g]),
            .ready   (rdy[g]),
            .busy    (bsy[g]),
            .err     (erra[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] word0(input logic [6:0] a);
        return {g_dut[0].u_dut.u_ram.mem_q[a], g_dut[0].u_dut.u_ram.mem_q[a+7'd1],
                g_dut[0].u_dut.u_ram.mem_q[a+7'd2], g_dut[0].u_dut.u_ram.mem_q[a+7'd3]};
    endfunction

    function automatic logic [31:0] word2(input logic [6:0] a);
        return {g_dut[2].u_dut.u_ram.mem_q[a], g_dut[2].u_dut.u_ram.mem_q[a+7'd1],
                g_dut[2].u_dut.u_ram.mem_q[a+7'd2], g_dut[2].u_dut.u_ram.mem_q[a+7'd3]};
    endfunction

    // One access: strobes sampled at edge N; lat = edges after N until ready.
    task automatic access(input int d, input bit w, input bit r, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rdata,
                          output logic e, output int lat);
        @(negedge clk);
        wr[d] = w; rd[d] = r; addr[d] = a; din[d] = wd;
        @(posedge clk); #1;
        wr[d] = 1'b0; rd[d] = 1'b0;
        check("busy_rise", {31'b0, bsy[d]}, 32'd1);
        lat = 0;
        while (!rdy[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rdy[d]) check("ready_timeout", 32'd0, 32'd1);
        rdata = dout[d];
        e = erra[d];
        @(posedge clk); #1;
        check("ready_pulse_end", {30'b0, rdy[d], bsy[d]}, 32'd0);
    endtask

    logic [31:0] rdata, init_w;
    logic        e;
    int          lat;

    initial begin
        for (int d = 0; d < 3; d++) begin addr[d] = '0; din[d] = '0; end

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_dout", dout[d], 32'd0);
            check("rst_flags", {29'b0, rdy[d], bsy[d], erra[d]}, 32'd0);
        end
        @(negedge clk);
        rst_n = 3'b111;

        // Read before any write returns whatever the storage holds.
        init_w = word0(7'h00);
        access(0, 0, 1, 32'h0, 32'h0, rdata, e, lat);
        check("rd0_lat", 32'(lat), 32'd1);
        check("rd0_data", rdata, init_w);

        access(0, 1, 0, 32'h8, 32'h12345678, rdata, e, lat);
        check("wr8_lat", 32'(lat), 32'd1);
        check("wr8_dout_hold", rdata, init_w);
        check("wr8_err", {31'b0, e}, 32'd0);
        check("bd_b8",  {24'b0, g_dut[0].u_dut.u_ram.mem_q[8]},  32'h12);
        check("bd_b9",  {24'b0, g_dut[0].u_dut.u_ram.mem_q[9]},  32'h34);
        check("bd_b10", {24'b0, g_dut[0].u_dut.u_ram.mem_q[10]}, 32'h56);
        check("bd_b11", {24'b0, g_dut[0].u_dut.u_ram.mem_q[11]}, 32'h78);
        access(0, 0, 1, 32'h8, 32'h0, rdata, e, lat);
        check("rd8_lat", 32'(lat), 32'd1);
        check("rd8_data", rdata, 32'h12345678);

        // Zero wait states, RD held high: ready on every second cycle.
        access(1, 1, 0, 32'h8, 32'h12345678, rdata, e, lat);
        check("w0_wr_lat", 32'(lat), 32'd0);
        @(negedge clk);
        rd[1] = 1'b1; addr[1] = 32'h8;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("w0_ready", {31'b0, rdy[1]}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 0) check("w0_data", dout[1], 32'h12345678);
        end
        rd[1] = 1'b0;

        // WR+RD together is a write; 0x84 wraps to 0x04.
        access(0, 1, 1, 32'h84, 32'hAABBCCDD, rdata, e, lat);
        check("wrap_wr_dout_hold", rdata, 32'h12345678);
        check("wrap_bd_w4", word0(7'h04), 32'hAABBCCDD);
        access(0, 0, 1, 32'h04, 32'h0, rdata, e, lat);
        check("wrap_rd4", rdata, 32'hAABBCCDD);

        // Misaligned write and read at 0x0A.
        access(0, 1, 0, 32'h0A, 32'hDEADBEEF, rdata, e, lat);
        check("mis_wr_lat", 32'(lat), 32'd1);
`ifdef DMEM_MISALIGN_ERR_EN
        check("mis_wr_err", {31'b0, e}, 32'd1);
        check("mis_bd_w8", word0(7'h08), 32'h12345678);
        access(0, 0, 1, 32'h0A, 32'h0, rdata, e, lat);
        check("mis_rd_err", {31'b0, e}, 32'd1);
        check("mis_rd_data", rdata, 32'h0);
`else
        check("mis_wr_err", {31'b0, e}, 32'd0);
        check("mis_bd_w8", word0(7'h08), 32'hDEADBEEF);
        access(0, 0, 1, 32'h0A, 32'h0, rdata, e, lat);
        check("mis_rd_err", {31'b0, e}, 32'd0);
        check("mis_rd_data", rdata, 32'hDEADBEEF);
`endif

        // Three wait states; reset during the second WAIT cycle drops the write.
        access(2, 1, 0, 32'h10, 32'h11223344, rdata, e, lat);
        check("w3_lat", 32'(lat), 32'd3);
        @(negedge clk);
        wr[2] = 1'b1; addr[2] = 32'h10; din[2] = 32'h55667788;
        @(posedge clk); #1;
        wr[2] = 1'b0;
        check("w3_busy_wait1", {31'b0, bsy[2]}, 32'd1);
        @(posedge clk); #1;
        check("w3_ready_wait2", {31'b0, rdy[2]}, 32'd0);
        @(negedge clk);
        rst_n[2] = 1'b0;
        @(posedge clk); #1;
        check("w3_rst_flags", {29'b0, rdy[2], bsy[2], erra[2]}, 32'd0);
        check("w3_rst_dout", dout[2], 32'd0);
        @(negedge clk);
        rst_n[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("w3_no_ready", {31'b0, rdy[2]}, 32'd0);
        end
        check("w3_bd_w16", word2(7'h10), 32'h11223344);

        // Request coincident with reset is ignored.
        @(negedge clk);
        rst_n[2] = 1'b0; rd[2] = 1'b1; addr[2] = 32'h10;
        @(posedge clk); #1;
        check("rstreq_busy", {31'b0, bsy[2]}, 32'd0);
        @(negedge clk);
        rd[2] = 1'b0; rst_n[2] = 1'b1;
        @(posedge clk); #1;
        check("rstreq_idle", {30'b0, rdy[2], bsy[2]}, 32'd0);

        access(2, 0, 1, 32'h10, 32'h0, rdata, e, lat);
        check("w3_rd_lat", 32'(lat), 32'd3);
        check("w3_rd_data", rdata, 32'h11223344);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
